// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and helpers for the multi-port register file
package regfile_pkg;

  localparam int REG_ZERO = 0;
  // Widest register the byte-merge helper handles; callers cast to and from it.
  localparam int MERGE_W  = 256;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic logic [MERGE_W-1:0] byte_merge(
    input logic [MERGE_W-1:0]   old_w,
    input logic [MERGE_W-1:0]   new_w,
    input logic [MERGE_W/8-1:0] be
  );
    logic [MERGE_W-1:0] res;
    res = old_w;
    for (int b = 0; b < MERGE_W/8; b++) begin
      if (be[b]) res[b*8 +: 8] = new_w[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - busy-bit scoreboard with set-wins arbitration and busy count
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int NREGS = 32,
  parameter  int NRD   = 2,
  parameter  int NWR   = 1,
  localparam int AW    = clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD-1:0]    rd_busy,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic [NWR-1:0]    wr_clr,
  input  logic              rsv_en,
  input  logic [AW-1:0]     rsv_addr,
  output logic [AW:0]       busy_cnt
);

  logic [NREGS-1:0] busy_q, busy_d;
  logic [NREGS-1:0] set_v, clr_v;
  logic [AW:0]      cnt_q, cnt_d;

  always_comb begin
    set_v = '0;
    clr_v = '0;
    if (rsv_en) set_v[rsv_addr] = 1'b1;
    for (int p = 0; p < NWR; p++) begin
      if (wr_en[p] && wr_clr[p]) clr_v[wr_addr[p*AW +: AW]] = 1'b1;
    end
    set_v[REG_ZERO] = 1'b0;
    clr_v[REG_ZERO] = 1'b0;
    // A fresh reservation overrides a retire hitting the same register.
    busy_d = (busy_q & ~clr_v) | set_v;
    cnt_d  = cnt_q;
    for (int r = 0; r < NREGS; r++) begin
      if (busy_d[r] && !busy_q[r])      cnt_d = cnt_d + (AW+1)'(1);
      else if (!busy_d[r] && busy_q[r]) cnt_d = cnt_d - (AW+1)'(1);
    end
  end

  always_comb begin
    rd_busy = '0;
    for (int k = 0; k < NRD; k++) begin
      rd_busy[k] = busy_q[rd_addr[k*AW +: AW]] & ~clr_v[rd_addr[k*AW +: AW]];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_cnt = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port MIPS GPR file with byte-enable writes, bypass and scoreboard
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int NREGS  = 32,
  parameter  int NRD    = 2,
  parameter  int NWR    = 1,
  localparam int AW     = clog2(NREGS),
  localparam int BW     = DATA_W / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD*AW-1:0]     rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic [NWR-1:0]        wr_en,
  input  logic [NWR*AW-1:0]     wr_addr,
  input  logic [NWR*DATA_W-1:0] wr_data,
  input  logic [NWR*BW-1:0]     wr_be,
  input  logic [NWR-1:0]        wr_clr,
  input  logic                  rsv_en,
  input  logic [AW-1:0]         rsv_addr,
  output logic [AW:0]           busy_cnt,
  output logic                  wr_conflict
);

  logic [DATA_W-1:0] reg_q [NREGS];
  logic [DATA_W-1:0] reg_d [NREGS];
  logic              wr_conflict_q, wr_conflict_d;

  // Ports are applied in ascending order so the higher index wins per byte.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      reg_d[r] = reg_q[r];
      for (int p = 0; p < NWR; p++) begin
        if (wr_en[p] && wr_addr[p*AW +: AW] == AW'(r) && r != REG_ZERO) begin
          reg_d[r] = DATA_W'(byte_merge(MERGE_W'(reg_d[r]),
                                        MERGE_W'(wr_data[p*DATA_W +: DATA_W]),
                                        (MERGE_W/8)'(wr_be[p*BW +: BW])));
        end
      end
    end
  end

  always_comb begin : read_path
    logic [AW-1:0]     a;
    logic [DATA_W-1:0] v;
    rd_data = '0;
    a       = '0;
    v       = '0;
    for (int k = 0; k < NRD; k++) begin
      a = rd_addr[k*AW +: AW];
      v = reg_q[a];
      for (int p = 0; p < NWR; p++) begin
        if (wr_en[p] && wr_addr[p*AW +: AW] == a) begin
          v = DATA_W'(byte_merge(MERGE_W'(v),
                                 MERGE_W'(wr_data[p*DATA_W +: DATA_W]),
                                 (MERGE_W/8)'(wr_be[p*BW +: BW])));
        end
      end
      if (a == AW'(REG_ZERO)) v = '0;
      rd_data[k*DATA_W +: DATA_W] = v;
    end
  end

  always_comb begin
    wr_conflict_d = 1'b0;
    for (int p = 0; p < NWR; p++) begin
      for (int q = p + 1; q < NWR; q++) begin
        if (wr_en[p] && wr_en[q] && wr_addr[p*AW +: AW] == wr_addr[q*AW +: AW] &&
            wr_addr[p*AW +: AW] != AW'(REG_ZERO)) begin
          wr_conflict_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_q         <= '{default: '0};
      wr_conflict_q <= 1'b0;
    end else begin
      reg_q         <= reg_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end

  assign wr_conflict = wr_conflict_q;

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD),
    .NWR   (NWR)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .rd_addr  (rd_addr),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_clr   (wr_clr),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .busy_cnt (busy_cnt)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed self-checking bench for regfile_mp (dual read, dual write)
module tb_regfile_mp;

  localparam int DATA_W = 32;
  localparam int NREGS  = 32;
  localparam int NRD    = 2;
  localparam int NWR    = 2;
  localparam int AW     = 5;
  localparam int BW     = 4;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [NRD*AW-1:0]     rd_addr;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_busy;
  logic [NWR-1:0]        wr_en;
  logic [NWR*AW-1:0]     wr_addr;
  logic [NWR*DATA_W-1:0] wr_data;
  logic [NWR*BW-1:0]     wr_be;
  logic [NWR-1:0]        wr_clr;
  logic                  rsv_en;
  logic [AW-1:0]         rsv_addr;
  logic [AW:0]           busy_cnt;
  logic                  wr_conflict;

  int n_vec = 0;
  int n_err = 0;

  regfile_mp #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .NRD    (NRD),
    .NWR    (NWR)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_busy     (rd_busy),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_be       (wr_be),
    .wr_clr      (wr_clr),
    .rsv_en      (rsv_en),
    .rsv_addr    (rsv_addr),
    .busy_cnt    (busy_cnt),
    .wr_conflict (wr_conflict)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    wr_en  = '0;
    wr_clr = '0;
    wr_be  = '0;
    rsv_en = 1'b0;
  endtask

  task automatic wr(input int p, input logic [AW-1:0] a, input logic [31:0] d,
                    input logic [3:0] be, input logic clr);
    wr_en[p]              = 1'b1;
    wr_addr[p*AW +: AW]   = a;
    wr_data[p*32 +: 32]   = d;
    wr_be[p*BW +: BW]     = be;
    wr_clr[p]             = clr;
  endtask

  task automatic rd(input int k, input logic [AW-1:0] a);
    rd_addr[k*AW +: AW] = a;
  endtask

  task automatic rsv(input logic [AW-1:0] a);
    rsv_en   = 1'b1;
    rsv_addr = a;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rd_addr  = '0;
    wr_addr  = '0;
    wr_data  = '0;
    rsv_addr = '0;
    #12;
    @(negedge clk);
    rst = 1'b1;
    rd(0, 5'd5);
    rd(1, 5'd31);
    #1;
    chk("rst_rd0", rd_data[31:0], 64'h0);
    chk("rst_rd1", rd_data[63:32], 64'h0);
    chk("rst_busy", rd_busy, 64'h0);
    chk("rst_cnt", busy_cnt, 64'h0);
    chk("rst_conf", wr_conflict, 64'h0);

    // write-through bypass, then array
    tick();
    wr(0, 5'd3, 32'hDEADBEEF, 4'hF, 1'b0);
    rd(0, 5'd3);
    #1;
    chk("byp_r3", rd_data[31:0], 64'hDEADBEEF);
    tick();
    idle();
    #1;
    chk("arr_r3", rd_data[31:0], 64'hDEADBEEF);

    // byte enables
    wr(0, 5'd7, 32'h11223344, 4'hF, 1'b0);
    tick();
    wr(0, 5'd7, 32'hAABBCCDD, 4'b0101, 1'b0);
    rd(1, 5'd7);
    #1;
    chk("byp_be_r7", rd_data[63:32], 64'h11BB33DD);
    tick();
    idle();
    #1;
    chk("arr_be_r7", rd_data[63:32], 64'h11BB33DD);

    // r0 stays zero
    wr(0, 5'd0, 32'hFFFFFFFF, 4'hF, 1'b0);
    rd(0, 5'd0);
    #1;
    chk("byp_r0", rd_data[31:0], 64'h0);
    tick();
    idle();
    #1;
    chk("arr_r0", rd_data[31:0], 64'h0);

    // dual-write collision on r9
    wr(0, 5'd9, 32'h000000AA, 4'hF, 1'b0);
    wr(1, 5'd9, 32'h0000BB00, 4'b0010, 1'b0);
    rd(0, 5'd9);
    #1;
    chk("byp_r9", rd_data[31:0], 64'h0000BBAA);
    chk("conf_pre", wr_conflict, 64'h0);
    tick();
    idle();
    #1;
    chk("arr_r9", rd_data[31:0], 64'h0000BBAA);
    chk("conf_on", wr_conflict, 64'h1);
    tick();
    chk("conf_off", wr_conflict, 64'h0);

    // dual write to distinct registers: no conflict
    wr(0, 5'd10, 32'h00000001, 4'hF, 1'b0);
    wr(1, 5'd11, 32'h00000002, 4'hF, 1'b0);
    tick();
    idle();
    rd(0, 5'd10);
    rd(1, 5'd11);
    #1;
    chk("arr_r10", rd_data[31:0], 64'h1);
    chk("arr_r11", rd_data[63:32], 64'h2);
    chk("conf_dist", wr_conflict, 64'h0);

    // scoreboard reserve / retire
    rsv(5'd4);
    tick();
    idle();
    rd(0, 5'd4);
    #1;
    chk("rsv_busy", rd_busy[0], 64'h1);
    chk("rsv_cnt", busy_cnt, 64'h1);
    wr(0, 5'd4, 32'h12345678, 4'hF, 1'b1);
    #1;
    chk("clr_busy_byp", rd_busy[0], 64'h0);
    chk("clr_data_byp", rd_data[31:0], 64'h12345678);
    tick();
    idle();
    #1;
    chk("clr_cnt", busy_cnt, 64'h0);
    chk("clr_busy", rd_busy[0], 64'h0);

    // set wins over same-cycle retire
    rsv(5'd4);
    wr(0, 5'd4, 32'h00000055, 4'hF, 1'b1);
    tick();
    idle();
    #1;
    chk("setwin_busy", rd_busy[0], 64'h1);
    chk("setwin_cnt", busy_cnt, 64'h1);

    // re-reserve busy r4, then reserve r0: count unchanged
    rsv(5'd4);
    tick();
    rsv(5'd0);
    tick();
    idle();
    rd(1, 5'd0);
    #1;
    chk("rersv_cnt", busy_cnt, 64'h1);
    chk("rsv_r0_busy", rd_busy[1], 64'h0);

    // retire r4, then build state for the mid-operation reset
    wr(0, 5'd4, 32'h0, 4'hF, 1'b1);
    tick();
    idle();
    rsv(5'd2);
    wr(0, 5'd2, 32'hCAFE0002, 4'hF, 1'b0);
    tick();
    idle();
    rsv(5'd6);
    wr(0, 5'd12, 32'h1, 4'hF, 1'b0);
    wr(1, 5'd12, 32'h2, 4'hF, 1'b0);
    tick();
    idle();
    rd(0, 5'd2);
    rd(1, 5'd6);
    #1;
    chk("pre_cnt", busy_cnt, 64'h2);
    chk("pre_busy", rd_busy, 64'h3);
    chk("pre_r2", rd_data[31:0], 64'hCAFE0002);
    chk("pre_conf", wr_conflict, 64'h1);
    rst = 1'b0;
    #1;
    chk("mrst_rd0", rd_data[31:0], 64'h0);
    chk("mrst_rd1", rd_data[63:32], 64'h0);
    chk("mrst_busy", rd_busy, 64'h0);
    chk("mrst_cnt", busy_cnt, 64'h0);
    chk("mrst_conf", wr_conflict, 64'h0);

    // first edge after release accepts a write; top-byte enable on r31
    @(negedge clk);
    rst = 1'b1;
    wr(0, 5'd31, 32'h99AABBCC, 4'b1000, 1'b0);
    tick();
    idle();
    rd(0, 5'd31);
    #1;
    chk("post_r31", rd_data[31:0], 64'h99000000);
    chk("post_cnt", busy_cnt, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port MIPS general-purpose register file with write-through bypass, per-byte write enables and an integrated busy-bit scoreboard. It sits between the decode stage (read ports and reservations) and the writeback stage (write ports). It supports dual-issue and long-latency units (load, mult/div) without external forwarding muxes for same-cycle writeback. Register 0 is hardwired to zero.

## Interface

Parameters:
- DATA_W, 32, register width in bits; multiple of 8.
- NREGS, 32, number of registers; power of two, at least 2.
- NRD, 2, number of read ports, 1 to 4.
- NWR, 1, number of write ports, 1 to 2.
- AW, clog2(NREGS), address width; derived, not overridable.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- rd_addr  in  NRD*AW  read addresses; port k is slice k.
- rd_data  out  NRD*DATA_W  read data, combinational, with bypass.
- rd_busy  out  NRD  addressed register has an outstanding reservation.
- wr_en  in  NWR  write strobe per port.
- wr_addr  in  NWR*AW  write addresses.
- wr_data  in  NWR*DATA_W  write data.
- wr_be  in  NWR*DATA_W/8  byte enables per write port.
- wr_clr  in  NWR  the write also retires that register's reservation.
- rsv_en  in  1  reserve a register (mark busy).
- rsv_addr  in  AW  register to reserve.
- busy_cnt  out  AW+1  number of registers currently busy.
- wr_conflict  out  1  registered pulse: two write ports hit the same nonzero register in the previous cycle.

## Operation

- Storage: NREGS x DATA_W flops. Reset clears every register, every busy bit, busy_cnt and wr_conflict to 0.
- Write: on a rising edge with wr_en[p] and wr_addr[p] != 0, bytes with wr_be[p][b]=1 update. Other bytes hold. Writes to r0 are discarded.
- Port priority: if both ports write the same register, the higher port index wins per byte. Bytes enabled only on the lower port still take the lower port's data. wr_conflict asserts for one cycle after such a collision.
- Read: rd_data[k] = 0 when rd_addr[k] == 0. Otherwise it is the stored value merged byte-wise with any same-cycle write to that address, using the same priority. This gives write-through bypass with zero latency.
- Scoreboard: one busy bit per register; bit 0 is constant 0.
  - rsv_en sets busy[rsv_addr] at the next edge.
  - A write with wr_en[p] and wr_clr[p] clears busy[wr_addr[p]] at the next edge.
  - If a set and a clear hit the same register in the same cycle, the set wins (a new reservation overrides the retire).
  - Reserving an already-busy register is legal and leaves it busy; there is no counting.
- rd_busy[k] = busy[rd_addr[k]] AND NOT (any same-cycle write to rd_addr[k] with wr_clr). The retiring value is bypassed, so decode needs no stall for it.
- busy_cnt is a registered population count of the busy bits. It is updated incrementally (+1, -1, 0 or -NWR per cycle, accounting for the set-wins rule). It never exceeds NREGS-1.

## Timing

- Read path: combinational from rd_addr, wr_* and the array. No registered read latency.
- Write path: 1 cycle. Data is visible through the array from the edge after wr_en, and visible via bypass in the same cycle.
- Busy bits, busy_cnt and wr_conflict: 1-cycle latency from their inputs.
- Reset: asynchronous assertion takes effect immediately, regardless of pending writes or reservations. Release is synchronised externally. The first write is accepted on the first edge with rst high.

## Structure

- Package regfile_pkg holds:
  - the clog2 function used to derive AW;
  - the constant REG_ZERO = 0;
  - the byte-merge function (stored word, new word, byte enables) used by both the write path and the bypass path, so the two cannot diverge.
- Sub-module regfile_scoreboard holds the busy-bit vector, set/clear arbitration, busy_cnt and the rd_busy lookup. It is parametrised by NREGS, NRD and NWR.
- The top level holds the data array, write priority, bypass, the zero-register rule and wr_conflict.

## Test plan

- Reset then read: after rst is released, reading r5 and r31 on all ports -> rd_data = 0, rd_busy = 0, busy_cnt = 0.
- Bypass: write r3 = 0xDEADBEEF with be = 4'hF; same cycle rd_addr[0] = 3 -> rd_data[0] = 0xDEADBEEF. Next cycle with wr_en low -> still 0xDEADBEEF.
- Byte enables and r0:
  - r7 = 0x11223344, then write 0xAABBCCDD with be = 4'b0101 -> r7 = 0x11BB33DD.
  - Write 0xFFFFFFFF to r0 -> r0 reads 0.
- Dual-write collision (NWR = 2): port0 writes r9 = 0x000000AA with be = 4'hF; port1 writes r9 = 0x0000BB00 with be = 4'b0010 -> r9 = 0x0000BBAA; wr_conflict = 1 for exactly one cycle.
- Scoreboard:
  - rsv r4 -> next cycle rd_busy = 1, busy_cnt = 1.
  - Write r4 with wr_clr -> same-cycle rd_busy = 0 with bypassed data; next cycle busy_cnt = 0.
  - rsv r4 and clearing write to r4 in the same cycle -> r4 stays busy.
- Reset mid-operation: with r2 written and r2/r6 reserved (busy_cnt = 2), pulse rst low between edges -> immediately all reads 0, rd_busy = 0, busy_cnt = 0, wr_conflict = 0.
